// File: rtl/addsub_sel_unit.sv
// Registered add/subtract slice with a 2:1 mux on the B operand and carry/overflow/zero flags.
// Define ADDSUB_SAT_EN to get unsigned saturating results instead of modulo wrap-around.
module addsub_sel_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  input  logic [WIDTH-1:0] datac,
  input  logic             sel_b,
  input  logic             add_sub,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  logic [WIDTH-1:0] bSel;
  logic [WIDTH-1:0] bOperand;
  logic [WIDTH:0]   sumExt;
  logic [WIDTH-1:0] rawResult;
  logic             carryRaw;
  logic             ovfRaw;

  logic [WIDTH-1:0] result_d, result_q;
  logic             carry_d, carry_q;
  logic             ovf_d, ovf_q;
  logic             valid_q;

  assign bSel = sel_b ? datac : datab;

  // Subtraction reuses the adder: A + ~B + 1, with the +1 entering as the carry-in.
  always_comb begin
    bOperand  = add_sub ? bSel : ~bSel;
    sumExt    = {1'b0, dataa} + {1'b0, bOperand} + {{WIDTH{1'b0}}, ~add_sub};
    rawResult = sumExt[WIDTH-1:0];
    carryRaw  = add_sub ? sumExt[WIDTH] : ~sumExt[WIDTH];
    if (add_sub) begin
      ovfRaw = (dataa[WIDTH-1] == bSel[WIDTH-1]) && (rawResult[WIDTH-1] != dataa[WIDTH-1]);
    end else begin
      ovfRaw = (dataa[WIDTH-1] != bSel[WIDTH-1]) && (rawResult[WIDTH-1] != dataa[WIDTH-1]);
    end
  end

  always_comb begin
    result_d = rawResult;
    carry_d  = carryRaw;
    ovf_d    = ovfRaw;
`ifdef ADDSUB_SAT_EN
    // Clamp on unsigned carry/borrow; flags still describe the unclamped operation.
    if (carryRaw) begin
      result_d = add_sub ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        result_q <= result_d;
        carry_q  <= carry_d;
        ovf_q    <= ovf_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign result    = result_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;
  assign zero      = (result_q == '0);

endmodule

// File: tb/tb_addsub_sel_unit.sv
// Directed self-checking bench for addsub_sel_unit (WIDTH=8); saturating expectations under ADDSUB_SAT_EN.
module tb_addsub_sel_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] dataa, datab, datac;
  logic       sel_b;
  logic       add_sub;
  logic       out_valid;
  logic [7:0] result;
  logic       carry_out;
  logic       overflow;
  logic       zero;

  int vectors = 0;
  int miscompares = 0;

  addsub_sel_unit #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .dataa     (dataa),
    .datab     (datab),
    .datac     (datac),
    .sel_b     (sel_b),
    .add_sub   (add_sub),
    .out_valid (out_valid),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then advance past the next rising edge.
  task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic s, input logic op);
    in_valid = v;
    dataa    = a;
    datab    = b;
    datac    = c;
    sel_b    = s;
    add_sub  = op;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] expRes, input logic expCout,
                             input logic expOvf, input logic expZero, input logic expValid);
    vectors++;
    assert (result === expRes) else begin
      miscompares++;
      $display("[TB] FAIL %s result: got %0d, expected %0d", tag, result, expRes);
      $error("[TB] %s result miscompare", tag);
    end
    vectors++;
    assert (carry_out === expCout) else begin
      miscompares++;
      $display("[TB] FAIL %s carry_out: got %b, expected %b", tag, carry_out, expCout);
      $error("[TB] %s carry_out miscompare", tag);
    end
    vectors++;
    assert (overflow === expOvf) else begin
      miscompares++;
      $display("[TB] FAIL %s overflow: got %b, expected %b", tag, overflow, expOvf);
      $error("[TB] %s overflow miscompare", tag);
    end
    vectors++;
    assert (zero === expZero) else begin
      miscompares++;
      $display("[TB] FAIL %s zero: got %b, expected %b", tag, zero, expZero);
      $error("[TB] %s zero miscompare", tag);
    end
    vectors++;
    assert (out_valid === expValid) else begin
      miscompares++;
      $display("[TB] FAIL %s out_valid: got %b, expected %b", tag, out_valid, expValid);
      $error("[TB] %s out_valid miscompare", tag);
    end
  endtask

  initial begin
    logic [7:0] expMux;
    reset = 1'b1;
    in_valid = 1'b0; dataa = '0; datab = '0; datac = '0; sel_b = 1'b0; add_sub = 1'b0;

    // Reset held while an operation is offered: it must be discarded.
    applyStimulus(1'b1, 8'd9, 8'd2, 8'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'd9, 8'd2, 8'd0, 1'b0, 1'b0);
    checkOutput("reset_hold", 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b0, 8'd9, 8'd2, 8'd0, 1'b0, 1'b0);
    checkOutput("post_reset_idle", 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Basic back-to-back operations.
    applyStimulus(1'b1, 8'd9, 8'd2, 8'd0, 1'b0, 1'b0);
    checkOutput("sub_9_2", 8'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'd3, 8'd2, 8'd0, 1'b0, 1'b1);
    checkOutput("add_3_2", 8'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'd10, 8'd2, 8'd0, 1'b0, 1'b1);
    checkOutput("add_10_2", 8'd12, 1'b0, 1'b0, 1'b0, 1'b1);

    // Zero and borrow.
    applyStimulus(1'b1, 8'd4, 8'd4, 8'd0, 1'b0, 1'b0);
    checkOutput("sub_4_4", 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 8'd0, 8'd2, 8'd0, 1'b0, 1'b0);
`ifdef ADDSUB_SAT_EN
    checkOutput("sub_0_2", 8'd0, 1'b1, 1'b0, 1'b1, 1'b1);
`else
    checkOutput("sub_0_2", 8'd254, 1'b1, 1'b0, 1'b0, 1'b1);
`endif
    applyStimulus(1'b1, 8'd9, 8'd10, 8'd0, 1'b0, 1'b0);
`ifdef ADDSUB_SAT_EN
    checkOutput("sub_9_10", 8'd0, 1'b1, 1'b0, 1'b1, 1'b1);
`else
    checkOutput("sub_9_10", 8'd255, 1'b1, 1'b0, 1'b0, 1'b1);
`endif

    // Overflow and carry.
    applyStimulus(1'b1, 8'd127, 8'd1, 8'd0, 1'b0, 1'b1);
    checkOutput("add_127_1", 8'd128, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'd255, 8'd1, 8'd0, 1'b0, 1'b1);
`ifdef ADDSUB_SAT_EN
    checkOutput("add_255_1", 8'd255, 1'b1, 1'b0, 1'b0, 1'b1);
`else
    checkOutput("add_255_1", 8'd0, 1'b1, 1'b0, 1'b1, 1'b1);
`endif
    applyStimulus(1'b1, 8'd128, 8'd1, 8'd0, 1'b0, 1'b0);
    checkOutput("sub_128_1", 8'd127, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'd250, 8'd10, 8'd0, 1'b0, 1'b1);
`ifdef ADDSUB_SAT_EN
    checkOutput("add_250_10", 8'd255, 1'b1, 1'b0, 1'b0, 1'b1);
`else
    checkOutput("add_250_10", 8'd4, 1'b1, 1'b0, 1'b0, 1'b1);
`endif

    // Operand mux, with the unselected input driven to X.
    applyStimulus(1'b1, 8'd10, 8'd2, 8'd7, 1'b0, 1'b1);
    checkOutput("mux_sel0", 8'd12, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'd10, 8'd2, 8'd7, 1'b1, 1'b1);
    checkOutput("mux_sel1", 8'd17, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'd10, 8'hxx, 8'd7, 1'b1, 1'b1);
    checkOutput("mux_xb", 8'd17, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'd10, 8'd2, 8'hxx, 1'b0, 1'b1);
    checkOutput("mux_xc", 8'd12, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      expMux = 8'd10 + ((k[2] ? k[1] : k[0]) ? 8'd1 : 8'd0);
      applyStimulus(1'b1, 8'd10, {7'd0, k[0]}, {7'd0, k[1]}, k[2], 1'b1);
      checkOutput($sformatf("mux_sweep%0d", k), expMux, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Valid gating: outputs hold while in_valid is low.
    applyStimulus(1'b1, 8'd5, 8'd3, 8'd0, 1'b0, 1'b1);
    checkOutput("gate_issue", 8'd8, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'd200, 8'd100, 8'd1, 1'b1, 1'b0);
    checkOutput("gate_hold1", 8'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 8'd255, 8'd255, 1'b0, 1'b1);
    checkOutput("gate_hold2", 8'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd128, 8'd1, 8'd3, 1'b1, 1'b0);
    checkOutput("gate_hold3", 8'd8, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-stream, then the first operation after release.
    reset = 1'b1;
    applyStimulus(1'b1, 8'd3, 8'd2, 8'd0, 1'b0, 1'b1);
    checkOutput("midreset", 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b1, 8'd9, 8'd2, 8'd0, 1'b0, 1'b0);
    checkOutput("first_after_reset", 8'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    checkOutput("drain", 8'd7, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
